mod_issuer: RTL and testbench

//  Initiator side of the start/done handshake of the iterative 32-bit modulo unit (mod).

---
 rtl/mod_pkg.sv | 19 +
 rtl/mod_watchdog.sv | 36 +++
 rtl/mod_issuer.sv | 144 ++++++++++++++
 tb/tb_mod_issuer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_pkg.sv
// mod_pkg: shared definitions for the modulo-unit issuer.
//   state_t             issuer FSM states (2-bit encoding)
//   DEF_WIDTH           default operand/result width
//   DEF_TIMEOUT_CYCLES  default WAIT-state watchdog limit
//   DEF_CNT_W           default watchdog counter width
package mod_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int unsigned DEF_WIDTH          = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
    localparam int unsigned DEF_CNT_W          = 13;

endpackage

// File: rtl/mod_watchdog.sv
// mod_watchdog: saturating cycle counter that flags when the limit is reached.
//   clk      in  clock
//   rst_n    in  synchronous active-low reset
//   clear    in  restart the count from zero (has priority over enable)
//   enable   in  count this cycle
//   expired  out counter has reached TIMEOUT_CYCLES-1
module mod_watchdog
    import mod_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LIMIT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/mod_issuer.sv
// mod_issuer: initiator for the iterative modulo unit's start/done handshake.
// Accepts one operand pair over req valid/ready, pulses mod_start, waits for
// mod_done (bounded by a watchdog) and returns A mod B over rsp valid/ready.
// A zero divisor is answered directly with rsp_dbz and the dividend.
//   clk, rst_n               clock, synchronous active-low reset
//   req_valid/ready/a/b      request channel (ready only in IDLE)
//   rsp_valid/ready          response channel
//   rsp_result/dbz/tmo       A mod B | A on divide-by-zero | 0 on timeout
//   mod_start                one-cycle start pulse to the modulo unit
//   mod_a, mod_b             registered operands, held through WAIT
//   mod_result, mod_done     unit result, valid while mod_done is high
module mod_issuer
    import mod_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_dbz,
    output logic             rsp_tmo,
    output logic             mod_start,
    output logic [WIDTH-1:0] mod_a,
    output logic [WIDTH-1:0] mod_b,
    input  logic [WIDTH-1:0] mod_result,
    input  logic             mod_done
);

    state_t state, state_next;

    logic accept, capture, timeout, wd_clear, wd_enable, wd_expired;
    // Set once mod_done has been seen low in the current WAIT; a done level
    // left over from the previous operation must not be taken as completion.
    logic seen_low;

    mod_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mod_start  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        wd_clear   = 1'b0;
        wd_enable  = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = (req_b == '0) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mod_start  = 1'b1;
                wd_clear   = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                wd_enable = 1'b1;
                // A genuine completion beats a watchdog expiry in the same cycle.
                if (mod_done && seen_low) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end else if (wd_expired) begin
                    timeout    = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mod_a      <= '0;
            mod_b      <= '0;
            rsp_result <= '0;
            rsp_dbz    <= 1'b0;
            rsp_tmo    <= 1'b0;
            seen_low   <= 1'b0;
        end else begin
            if (accept) begin
                mod_a <= req_a;
                mod_b <= req_b;
                if (req_b == '0) begin
                    rsp_result <= req_a;
                    rsp_dbz    <= 1'b1;
                end
            end
            if (state == S_ISSUE) begin
                seen_low <= 1'b0;
            end else if ((state == S_WAIT) && !mod_done) begin
                seen_low <= 1'b1;
            end
            if (capture) begin
                rsp_result <= mod_result;
            end
            if (timeout) begin
                rsp_result <= '0;
                rsp_tmo    <= 1'b1;
            end
            if (rsp_valid && rsp_ready) begin
                rsp_result <= '0;
                rsp_dbz    <= 1'b0;
                rsp_tmo    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod_issuer.sv
// tb_mod_issuer: directed scenarios plus randomized traffic for mod_issuer,
// checked every cycle against a transaction-level reference model, with a
// behavioural modulo unit answering mod_start after a configurable delay.
module tb_mod_issuer;

    localparam int unsigned W   = 32;
    localparam int unsigned TMO = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready;
    logic [W-1:0] req_a, req_b;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_dbz, rsp_tmo;
    logic         mod_start;
    logic [W-1:0] mod_a, mod_b, mod_result;
    logic         mod_done;

    always #5 clk = ~clk;

    mod_issuer #(
        .WIDTH         (W),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_dbz   (rsp_dbz),
        .rsp_tmo   (rsp_tmo),
        .mod_start (mod_start),
        .mod_a     (mod_a),
        .mod_b     (mod_b),
        .mod_result(mod_result),
        .mod_done  (mod_done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural modulo unit ----------------
    // cfg_L : done rises L cycles after the mod_start cycle
    // cfg_h : done is (stale, garbage) high for the first h WAIT cycles
    // cfg_never : unit never completes
    int   cfg_L = 4, cfg_h = 0;
    logic cfg_never = 1'b0;
    logic unit_poison = 1'b0;

    initial begin
        int           u_k, u_L, u_h;
        logic         u_active, u_never, nd;
        logic [W-1:0] u_res, nr;
        u_active   = 1'b0;
        u_k = 0; u_L = 0; u_h = 0; u_never = 1'b0; u_res = '0;
        mod_done   = 1'b0;
        mod_result = '0;
        forever begin
            @(posedge clk);
            nd = mod_done;
            nr = mod_result;
            if (unit_poison) begin
                u_active = 1'b0;
                nd = 1'b1;
                nr = $urandom;
            end else begin
                if (mod_start) begin
                    u_active = 1'b1;
                    u_k      = 1;
                    u_L      = cfg_L;
                    u_h      = cfg_h;
                    u_never  = cfg_never;
                    u_res    = (mod_b == '0) ? '0 : mod_a % mod_b;
                end else if (u_active) begin
                    u_k++;
                end
                if (u_active) begin
                    if (u_k <= u_h) begin
                        nd = 1'b1; nr = $urandom;
                    end else if (!u_never && u_k >= u_L) begin
                        nd = 1'b1; nr = u_res;
                    end else begin
                        nd = 1'b0; nr = $urandom;
                    end
                end
            end
            #1;
            mod_done   = nd;
            mod_result = nr;
        end
    end

    // ---------------- reference model ----------------
    // Transaction view: a request is accepted when idle; nonzero divisor means a
    // start cycle, then up to TMO waiting cycles scanning mod_done; response held
    // until rsp_ready.
    logic         m_busy, m_start, m_wait, m_rsp, m_dbz, m_tmo, w_low;
    logic [W-1:0] m_ma, m_mb, m_res;
    int           w_n;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_busy = 0; m_start = 0; m_wait = 0; m_rsp = 0;
            m_dbz = 0; m_tmo = 0; m_ma = '0; m_mb = '0; m_res = '0;
            w_n = 0; w_low = 0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1;
                m_ma   = req_a;
                m_mb   = req_b;
                if (req_b == '0) begin
                    m_rsp = 1; m_res = req_a; m_dbz = 1;
                end else begin
                    m_start = 1;
                end
            end
        end else if (m_start) begin
            m_start = 0; m_wait = 1; w_n = 0; w_low = 0;
        end else if (m_wait) begin
            if (mod_done && w_low) begin
                m_wait = 0; m_rsp = 1; m_res = m_ma % m_mb;
            end else if (w_n == TMO - 1) begin
                m_wait = 0; m_rsp = 1; m_res = '0; m_tmo = 1;
            end else begin
                if (!mod_done) w_low = 1;
                w_n++;
            end
        end else if (m_rsp && rsp_ready) begin
            m_rsp = 0; m_busy = 0; m_dbz = 0; m_tmo = 0;
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            check("req_ready", W'(req_ready), W'(!m_busy));
            check("rsp_valid", W'(rsp_valid), W'(m_rsp));
            check("mod_start", W'(mod_start), W'(m_start));
            check("mod_a", mod_a, m_ma);
            check("mod_b", mod_b, m_mb);
            check("rsp_dbz", W'(rsp_dbz), W'(m_dbz));
            check("rsp_tmo", W'(rsp_tmo), W'(m_tmo));
            if (m_rsp) check("rsp_result", rsp_result, m_res);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int i;
        req_valid = 1'b1; req_a = a; req_b = b;
        i = 0;
        while (!req_ready && i < 100) begin
            tick();
            i++;
        end
        check("accept_bound", W'(req_ready), W'(1));
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int p);
        int i;
        i = 0;
        while (!rsp_valid && i < 100) begin
            tick();
            i++;
        end
        check("rsp_bound", W'(rsp_valid), W'(1));
        p = cyc;
    endtask

    initial begin
        int s, p;
        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

        // 1. reset
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_req_ready", W'(req_ready), W'(1));
        check("rst_rsp_valid", W'(rsp_valid), W'(0));
        check("rst_mod_start", W'(mod_start), W'(0));
        check("rst_rsp_result", rsp_result, '0);
        check("rst_mod_a", mod_a, '0);
        check("rst_mod_b", mod_b, '0);
        check("rst_flags", W'({rsp_dbz, rsp_tmo}), W'(0));

        // 2. normal: 17 mod 5, done 4 cycles after start
        cfg_L = 4; cfg_h = 0; cfg_never = 1'b0;
        send(32'd17, 32'd5);
        s = cyc;
        check("norm_start_now", W'(mod_start), W'(1));
        tick();
        check("norm_start_once", W'(mod_start), W'(0));
        wait_rsp(p);
        check("norm_latency", W'(p - s), W'(5));
        check("norm_result", rsp_result, 32'd2);
        check("norm_flags", W'({rsp_dbz, rsp_tmo}), W'(0));
        tick();

        // 3. divide by zero
        send(32'h1234, 32'd0);
        check("dbz_no_start", W'(mod_start), W'(0));
        check("dbz_valid_next", W'(rsp_valid), W'(1));
        check("dbz_result", rsp_result, 32'h1234);
        check("dbz_flag", W'(rsp_dbz), W'(1));
        tick();

        // 4. timeout, then recovery
        cfg_never = 1'b1;
        send(32'hdead, 32'd7);
        s = cyc;
        wait_rsp(p);
        check("tmo_wait_cycles", W'(p - s - 1), W'(TMO));
        check("tmo_flag", W'(rsp_tmo), W'(1));
        check("tmo_result", rsp_result, '0);
        tick();
        cfg_never = 1'b0; cfg_L = 3;
        send(32'd9, 32'd4);
        wait_rsp(p);
        check("post_tmo_result", rsp_result, 32'd1);
        check("post_tmo_flag", W'(rsp_tmo), W'(0));
        tick();

        // done in the last WAIT cycle wins over expiry
        cfg_L = TMO;
        send(32'd1000, 32'd33);
        s = cyc;
        wait_rsp(p);
        check("race_latency", W'(p - s), W'(TMO + 1));
        check("race_result", rsp_result, 32'd10);
        check("race_no_tmo", W'(rsp_tmo), W'(0));
        tick();

        // 5. backpressure
        cfg_L = 3; rsp_ready = 1'b0;
        send(32'd100, 32'd7);
        wait_rsp(p);
        req_valid = 1'b1; req_a = 32'd55; req_b = 32'd6;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", W'(rsp_valid), W'(1));
            check("bp_result", rsp_result, 32'd2);
            check("bp_req_ready", W'(req_ready), W'(0));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_idle_after_hs", W'(req_ready), W'(1));
        check("bp_no_start_yet", W'(mod_start), W'(0));
        tick();
        req_valid = 1'b0;
        check("bp_second_start", W'(mod_start), W'(1));
        wait_rsp(p);
        check("bp_second_result", rsp_result, 32'd1);
        tick();

        // 6. reset two cycles after mod_start, stale done afterwards
        cfg_L = 20;
        send(32'd77, 32'd3);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        unit_poison = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("rmid_idle", W'(req_ready), W'(1));
            check("rmid_no_rsp", W'(rsp_valid), W'(0));
            tick();
        end
        check("rmid_mod_a", mod_a, '0);
        unit_poison = 1'b0;
        cfg_L = 4; cfg_h = 1;
        send(32'd50, 32'd7);
        wait_rsp(p);
        check("rmid_stale_ignored", rsp_result, 32'd1);
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom % 4) != 0;
            req_a     = $urandom;
            case ($urandom % 4)
                0:       req_b = '0;
                1:       req_b = $urandom;
                default: req_b = W'($urandom_range(1, 20));
            endcase
            rsp_ready = ($urandom % 3) != 0;
            cfg_h     = int'($urandom % 3);
            cfg_L     = cfg_h + 2 + int'($urandom % 8);
            cfg_never = ($urandom % 6) == 0;
            rst_n     = ($urandom % 400) != 0;
            tick();
        end
        rst_n = 1'b1; req_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "global timeout");
    end

endmodule
